// File: rtl/sensor_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sensor_sequencer                                                  |
// | Desc   : periodic ADC sampling, contact debounce and temperature flags     |
// |          feeding the asphyxia-prevention state machine.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sensor_sequencer #(
  parameter int         PERIOD   = 100000,
  parameter int         DEB      = 4,
  parameter int         TIMEOUT  = 1000,
  parameter logic [7:0] T28_CODE = 8'd112,
  parameter logic [7:0] T30_CODE = 8'd120,
  parameter logic [7:0] HYST     = 8'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Presencia_raw,
  input  logic       Ignicion_raw,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic       adc_start,
  output logic       Presencia,
  output logic       Ignicion,
  output logic       Temp_28,
  output logic       Temp_30,
  output logic       paso,
  output logic       error_adc
);

  localparam int c_PER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int c_TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_DEB_W = ($clog2(DEB + 1) > 3) ? $clog2(DEB + 1) : 3;

  localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(PERIOD - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_MAX  = c_DEB_W'(DEB);

  // Clear thresholds saturate at zero instead of wrapping.
  localparam logic [7:0] c_T28_LOW = (T28_CODE > HYST) ? T28_CODE - HYST : 8'd0;
  localparam logic [7:0] c_T30_LOW = (T30_CODE > HYST) ? T30_CODE - HYST : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_STEP   = 3'd4
  } state_t;

  state_t               r_state,   w_next_state;
  logic [c_PER_W-1:0]   r_per_cnt, w_per_cnt;
  logic [c_TO_W-1:0]    r_to_cnt,  w_to_cnt;
  logic [c_DEB_W-1:0]   r_pres_cnt, w_pres_cnt;
  logic [c_DEB_W-1:0]   r_ign_cnt,  w_ign_cnt;
  logic [7:0]           r_data,    w_data;
  logic                 r_timeout, w_timeout;
  logic                 r_presencia, w_presencia;
  logic                 r_ignicion,  w_ignicion;
  logic                 r_t28, w_t28;
  logic                 r_t30, w_t30;
  logic                 r_err, w_err;
  logic                 r_adc_start, r_paso;
  logic [c_DEB_W:0]     w_deb_p, w_deb_i;

  function automatic logic [c_DEB_W:0] deb_next(input logic sample, input logic cur,
                                                input logic [c_DEB_W-1:0] cnt);
    logic [c_DEB_W-1:0] w_inc;
    w_inc = cnt + 1'b1;
    if (sample == cur) return {cur, {c_DEB_W{1'b0}}};
    if (w_inc == c_DEB_MAX) return {sample, {c_DEB_W{1'b0}}};
    return {cur, w_inc};
  endfunction

  function automatic logic hyst_next(input logic cur, input logic [7:0] d,
                                     input logic [7:0] thr, input logic [7:0] low);
    if (d >= thr) return 1'b1;
    if (d < low) return 1'b0;
    return cur;
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_per_cnt    = r_per_cnt;
    w_to_cnt     = r_to_cnt;
    w_pres_cnt   = r_pres_cnt;
    w_ign_cnt    = r_ign_cnt;
    w_data       = r_data;
    w_timeout    = r_timeout;
    w_presencia  = r_presencia;
    w_ignicion   = r_ignicion;
    w_t28        = r_t28;
    w_t30        = r_t30;
    w_err        = r_err;
    w_deb_p      = deb_next(Presencia_raw, r_presencia, r_pres_cnt);
    w_deb_i      = deb_next(Ignicion_raw, r_ignicion, r_ign_cnt);
    case (r_state)
      S_IDLE: begin
        if (r_per_cnt == c_PER_LAST) begin
          w_per_cnt    = '0;
          w_next_state = S_START;
        end else begin
          w_per_cnt = r_per_cnt + 1'b1;
        end
      end
      S_START: begin
        w_to_cnt     = '0;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse on the expiry cycle still wins over the timeout.
        if (adc_done) begin
          w_data       = adc_data;
          w_timeout    = 1'b0;
          w_next_state = S_UPDATE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_UPDATE;
        end else begin
          w_to_cnt = r_to_cnt + 1'b1;
        end
      end
      S_UPDATE: begin
        w_err = r_timeout;
        if (r_timeout) begin
          w_t28 = 1'b1;
          w_t30 = 1'b1;
        end else begin
          w_t28 = hyst_next(r_t28, r_data, T28_CODE, c_T28_LOW);
          w_t30 = hyst_next(r_t30, r_data, T30_CODE, c_T30_LOW);
        end
        {w_presencia, w_pres_cnt} = w_deb_p;
        {w_ignicion,  w_ign_cnt}  = w_deb_i;
        w_next_state = S_STEP;
      end
      S_STEP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_per_cnt   <= '0;
      r_to_cnt    <= '0;
      r_pres_cnt  <= '0;
      r_ign_cnt   <= '0;
      r_data      <= '0;
      r_timeout   <= 1'b0;
      r_presencia <= 1'b0;
      r_ignicion  <= 1'b0;
      r_t28       <= 1'b0;
      r_t30       <= 1'b0;
      r_err       <= 1'b0;
      r_adc_start <= 1'b0;
      r_paso      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_per_cnt   <= w_per_cnt;
      r_to_cnt    <= w_to_cnt;
      r_pres_cnt  <= w_pres_cnt;
      r_ign_cnt   <= w_ign_cnt;
      r_data      <= w_data;
      r_timeout   <= w_timeout;
      r_presencia <= w_presencia;
      r_ignicion  <= w_ignicion;
      r_t28       <= w_t28;
      r_t30       <= w_t30;
      r_err       <= w_err;
      r_adc_start <= (w_next_state == S_START);
      r_paso      <= (w_next_state == S_STEP);
    end
  end

  assign adc_start = r_adc_start;
  assign paso      = r_paso;
  assign Presencia = r_presencia;
  assign Ignicion  = r_ignicion;
  assign Temp_28   = r_t28;
  assign Temp_30   = r_t30;
  assign error_adc = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sensor_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sensor_sequencer                                               |
// | Desc   : randomized round-level bench for sensor_sequencer                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sensor_sequencer;
  localparam int PERIOD  = 8;
  localparam int DEB     = 3;
  localparam int TIMEOUT = 16;
  localparam int T28     = 112;
  localparam int T30     = 120;
  localparam int HYST    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Presencia_raw = 1'b0;
  logic       Ignicion_raw = 1'b0;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data = 8'd0;
  logic       adc_start, Presencia, Ignicion, Temp_28, Temp_30, paso, error_adc;

  always #5 clk = ~clk;

  sensor_sequencer #(
    .PERIOD(PERIOD), .DEB(DEB), .TIMEOUT(TIMEOUT),
    .T28_CODE(8'(T28)), .T30_CODE(8'(T30)), .HYST(8'(HYST))
  ) dut (
    .clk(clk), .reset(reset),
    .Presencia_raw(Presencia_raw), .Ignicion_raw(Ignicion_raw),
    .adc_done(adc_done), .adc_data(adc_data), .adc_start(adc_start),
    .Presencia(Presencia), .Ignicion(Ignicion),
    .Temp_28(Temp_28), .Temp_30(Temp_30),
    .paso(paso), .error_adc(error_adc)
  );

  int n_pass = 0;
  int n_checks = 0;

  // Round-level reference: per-round sample history and last-flip index per contact.
  bit         m_t28, m_t30, m_err;
  bit         m_out[2];
  int         last_flip[2];
  logic [1:0] hist[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit thr_flag(input bit cur, input int d, input int t);
    int low;
    low = (t > HYST) ? t - HYST : 0;
    if (d >= t) return 1'b1;
    if (d < low) return 1'b0;
    return cur;
  endfunction

  task automatic model_reset();
    m_t28 = 0; m_t30 = 0; m_err = 0;
    m_out[0] = 0; m_out[1] = 0;
    last_flip[0] = 0; last_flip[1] = 0;
    hist.delete();
  endtask

  // A contact flips once its last DEB samples since the previous flip all disagree with it.
  task automatic model_round(input bit timed_out, input int d, input bit p, input bit i);
    int n;
    bit all;
    hist.push_back({i, p});
    n = hist.size();
    for (int c = 0; c < 2; c++) begin
      all = ((n - last_flip[c]) >= DEB);
      for (int k = n - DEB; k < n; k++)
        if (k >= 0 && hist[k][c] == m_out[c]) all = 0;
      if (all) begin
        m_out[c] = ~m_out[c];
        last_flip[c] = n;
      end
    end
    if (timed_out) begin
      m_t28 = 1; m_t30 = 1; m_err = 1;
    end else begin
      m_t28 = thr_flag(m_t28, d, T28);
      m_t30 = thr_flag(m_t30, d, T30);
      m_err = 0;
    end
  endtask

  // One sampling round: dly = WAIT cycle carrying adc_done (0 = never answers).
  task automatic round(input int exp_wait, input int dly, input int d,
                       input bit p, input bit i, input bit spur);
    int k;
    bit seen;
    Presencia_raw = p;
    Ignicion_raw  = i;
    k = 0; seen = 0;
    while (!seen && k < exp_wait + 4) begin
      step(); k++;
      if (k == 1) check("paso_width", paso, 0);
      adc_done = 1'b0;
      if (spur && k == 3) begin
        adc_done = 1'b1;
        adc_data = 8'd255;
      end
      if (adc_start) seen = 1;
    end
    adc_done = 1'b0;
    check("start_time", k, exp_wait);
    if (!seen) return;
    k = 0; seen = 0;
    while (!seen && k < TIMEOUT + 6) begin
      step(); k++;
      if (k == 1) check("start_width", adc_start, 0);
      adc_done = (k == dly);
      adc_data = (k == dly) ? d[7:0] : 8'($urandom);
      if (paso) seen = 1;
    end
    adc_done = 1'b0;
    check("paso_time", k, (dly > 0) ? dly + 2 : TIMEOUT + 2);
    model_round(dly == 0, d, p, i);
    check("Temp_28", Temp_28, m_t28);
    check("Temp_30", Temp_30, m_t30);
    check("Presencia", Presencia, m_out[0]);
    check("Ignicion", Ignicion, m_out[1]);
    check("error_adc", error_adc, m_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_paso"}, paso, 0);
    check({tag, "_Presencia"}, Presencia, 0);
    check({tag, "_Ignicion"}, Ignicion, 0);
    check({tag, "_Temp_28"}, Temp_28, 0);
    check({tag, "_Temp_30"}, Temp_30, 0);
    check({tag, "_error_adc"}, error_adc, 0);
  endtask

  initial begin
    int k;
    int dly, d;
    bit p, i;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // First round: answer one cycle after adc_start with 115.
    round(PERIOD, 1, 115, 0, 0, 0);
    check("first_t28", Temp_28, 1);
    check("first_t30", Temp_30, 0);

    // Falling temperature with presence held high.
    round(PERIOD + 1, 3, 121, 1, 0, 0);
    round(PERIOD + 1, 7, 119, 1, 1, 0);
    round(PERIOD + 1, 2, 117, 1, 0, 0);
    round(PERIOD + 1, 12, 110, 1, 0, 0);

    // Release presence, then a single-round glitch.
    round(PERIOD + 1, 4, 115, 0, 0, 0);
    round(PERIOD + 1, 4, 115, 0, 0, 0);
    round(PERIOD + 1, 4, 115, 0, 0, 0);
    round(PERIOD + 1, 4, 115, 1, 0, 0);
    round(PERIOD + 1, 4, 115, 0, 0, 0);
    round(PERIOD + 1, 4, 115, 0, 0, 0);

    // Timeout, then recovery with a cold reading.
    round(PERIOD + 1, 0, 0, 0, 0, 0);
    round(PERIOD + 1, 5, 100, 0, 0, 0);
    check("recover_t28", Temp_28, 0);

    // Spurious done in IDLE plus done on the last WAIT cycle.
    round(PERIOD + 1, TIMEOUT, 125, 0, 0, 1);

    // Reset in the middle of WAIT.
    k = 0;
    while (!adc_start && k < PERIOD + 4) begin
      step(); k++;
    end
    check("rst_wait_start", k, PERIOD + 1);
    repeat (3) step();
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    reset = 1'b0;
    adc_done = 1'b1;
    adc_data = 8'd255;
    model_reset();
    round(PERIOD, 2, 105, 0, 0, 0);

    // Randomized rounds.
    p = 0; i = 0;
    for (int r = 0; r < 24; r++) begin
      dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      d   = $urandom_range(106, 125);
      if ($urandom_range(0, 3) == 0) p = ~p;
      if ($urandom_range(0, 3) == 0) i = ~i;
      round(PERIOD + 1, dly, d, p, i, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
